// File: rtl/ifft_4_seq_if.sv
// Frame-in / frame-out handshake bundle for the 4-point inverse DFT.
interface ifft_4_seq_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
    logic                         ovf;

    // Upstream/downstream side that feeds frames and consumes results
    modport master (
        output in_valid, x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i, out_ready,
        input  in_ready, out_valid, y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i, ovf
    );

    // Transform block side
    modport slave (
        input  in_valid, x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i, out_ready,
        output in_ready, out_valid, y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i, ovf
    );
endinterface

// File: rtl/ifft_4_seq.sv
// Sequential 4-point radix-2 inverse DFT: latch frame, two registered
// butterfly stages, then hold the result until downstream accepts it.
module ifft_4_seq #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter bit          SCALE      = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    ifft_4_seq_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned FW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, S1, S2, OUT} state_t;

    state_t               state_q, state_d;
    logic signed [FW-1:0] xr_q [4], xr_d [4], xi_q [4], xi_d [4];
    logic signed [FW-1:0] ar_q [2], ar_d [2], ai_q [2], ai_d [2];
    logic signed [FW-1:0] br_q [2], br_d [2], bi_q [2], bi_d [2];
    logic signed [FW-1:0] fr [4], fi [4];
    logic signed [W-1:0]  yr_q [4], yr_d [4], yi_q [4], yi_d [4];
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 any_wide;

    // Final result in W bits: floor divide by 4, or plain wrap when unscaled
    function automatic logic signed [W-1:0] scale_fn(input logic signed [FW-1:0] v);
        if (SCALE) return W'(v >>> 2);
        return W'(v);
    endfunction

    // True when a full-precision value is representable in W signed bits
    function automatic logic fits_fn(input logic signed [FW-1:0] v);
        logic [2:0] top;
        top = v[FW-1:W-1];
        return (top == 3'b000) || (top == 3'b111);
    endfunction

    // Stage-2 butterflies at full precision; +j twiddle is swap/negate
    always_comb begin
        fr[0] = ar_q[0] + br_q[0];
        fi[0] = ai_q[0] + bi_q[0];
        fr[2] = ar_q[0] - br_q[0];
        fi[2] = ai_q[0] - bi_q[0];
        fr[1] = ar_q[1] - bi_q[1];
        fi[1] = ai_q[1] + br_q[1];
        fr[3] = ar_q[1] + bi_q[1];
        fi[3] = ai_q[1] - br_q[1];
        any_wide = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!fits_fn(fr[i]) || !fits_fn(fi[i])) any_wide = 1'b1;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;
        yr_d    = yr_q;
        yi_d    = yi_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    xr_d[0] = FW'(bus.x0_r);
                    xi_d[0] = FW'(bus.x0_i);
                    xr_d[1] = FW'(bus.x1_r);
                    xi_d[1] = FW'(bus.x1_i);
                    xr_d[2] = FW'(bus.x2_r);
                    xi_d[2] = FW'(bus.x2_i);
                    xr_d[3] = FW'(bus.x3_r);
                    xi_d[3] = FW'(bus.x3_i);
                    state_d = S1;
                end
            end
            S1: begin
                ar_d[0] = xr_q[0] + xr_q[2];
                ai_d[0] = xi_q[0] + xi_q[2];
                ar_d[1] = xr_q[0] - xr_q[2];
                ai_d[1] = xi_q[0] - xi_q[2];
                br_d[0] = xr_q[1] + xr_q[3];
                bi_d[0] = xi_q[1] + xi_q[3];
                br_d[1] = xr_q[1] - xr_q[3];
                bi_d[1] = xi_q[1] - xi_q[3];
                state_d = S2;
            end
            S2: begin
                for (int i = 0; i < 4; i++) begin
                    yr_d[i] = scale_fn(fr[i]);
                    yi_d[i] = scale_fn(fi[i]);
                end
                ovf_d   = SCALE ? 1'b0 : any_wide;
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == OUT);
        in_ready_d  = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
                yr_q[i] <= '0;
                yi_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                ar_q[i] <= '0;
                ai_q[i] <= '0;
                br_q[i] <= '0;
                bi_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            for (int i = 0; i < 4; i++) begin
                xr_q[i] <= xr_d[i];
                xi_q[i] <= xi_d[i];
                yr_q[i] <= yr_d[i];
                yi_q[i] <= yi_d[i];
            end
            for (int i = 0; i < 2; i++) begin
                ar_q[i] <= ar_d[i];
                ai_q[i] <= ai_d[i];
                br_q[i] <= br_d[i];
                bi_q[i] <= bi_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.y0_r      = yr_q[0];
    assign bus.y0_i      = yi_q[0];
    assign bus.y1_r      = yr_q[1];
    assign bus.y1_i      = yi_q[1];
    assign bus.y2_r      = yr_q[2];
    assign bus.y2_i      = yi_q[2];
    assign bus.y3_r      = yr_q[3];
    assign bus.y3_i      = yi_q[3];
endmodule
